// File: rtl/button_sync_multi.sv
// Multi-channel push-button front end: flop synchroniser, counter debouncer
// and per-channel FSM producing level, press/release and auto-repeat pulses.
module button_sync_multi #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_RATE     = 5
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [N-1:0] Bi,
  input  logic         RepeatEn,
  output logic [N-1:0] Level,
  output logic [N-1:0] Press,
  output logic [N-1:0] Release,
  output logic         AnyPress
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX) + 1;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_WAIT = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] REL_WAIT   = 2'd3;

  localparam logic [DW-1:0] DONE  = DW'(1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RDLY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RRATE = RW'(REPEAT_RATE - 1);

  logic [SYNC_STAGES-1:0][N-1:0] sync;
  logic [N-1:0]                  bs;

  always_ff @(posedge Clk) begin
    if (Reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], Bi};
  end

  assign bs = sync[SYNC_STAGES-1];

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [1:0]    st;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;
    logic          rep;
    logic          lvl;
    logic          prs;
    logic          rls;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        st   <= IDLE;
        dcnt <= '0;
        rcnt <= '0;
        rep  <= 1'b0;
        lvl  <= 1'b0;
        prs  <= 1'b0;
        rls  <= 1'b0;
      end else begin
        prs <= 1'b0;
        rls <= 1'b0;
        unique case (st)
          IDLE: begin
            rcnt <= '0;
            rep  <= 1'b0;
            if (bs[i]) begin
              st   <= PRESS_WAIT;
              dcnt <= DONE;
            end
          end
          PRESS_WAIT: begin
            if (!bs[i]) begin
              st   <= IDLE;
              dcnt <= '0;
            end else if (dcnt == DLAST) begin
              st   <= HELD;
              dcnt <= '0;
              rcnt <= '0;
              rep  <= 1'b0;
              lvl  <= 1'b1;
              prs  <= 1'b1;
            end else begin
              dcnt <= dcnt + DONE;
            end
          end
          HELD: begin
            // rep selects the long first interval or the shorter rate
            if (!bs[i]) begin
              st   <= REL_WAIT;
              dcnt <= DONE;
            end else if (!RepeatEn) begin
              rcnt <= '0;
              rep  <= 1'b0;
            end else if (rcnt == (rep ? RRATE : RDLY)) begin
              rcnt <= '0;
              rep  <= 1'b1;
              prs  <= 1'b1;
            end else begin
              rcnt <= rcnt + RW'(1);
            end
          end
          REL_WAIT: begin
            if (bs[i]) begin
              st   <= HELD;
              dcnt <= '0;
              rcnt <= '0;
              rep  <= 1'b0;
            end else if (dcnt == DLAST) begin
              st   <= IDLE;
              dcnt <= '0;
              lvl  <= 1'b0;
              rls  <= 1'b1;
            end else begin
              dcnt <= dcnt + DONE;
            end
          end
          default: begin
            st   <= IDLE;
            dcnt <= '0;
            rcnt <= '0;
            rep  <= 1'b0;
            lvl  <= 1'b0;
          end
        endcase
      end
    end

    assign Level[i]   = lvl;
    assign Press[i]   = prs;
    assign Release[i] = rls;
  end

  assign AnyPress = |Press;

endmodule

// File: tb/tb_button_sync_multi.sv
// Bench for button_sync_multi: directed scenarios plus random bursts
// compared each cycle against a stable-run/anchor reference model.
module tb_button_sync_multi;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 5;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         RepeatEn = 1'b0;
  logic [N-1:0] Bi = '0;
  logic [N-1:0] Level, Press, Release;
  logic         AnyPress;

  logic [0:0] bib = '0, lvb, prb, rlb;
  logic [0:0] bic = '0, lvc, prc, rlc;
  logic       anyb, anyc;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  button_sync_multi #(
    .N(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Bi(Bi), .RepeatEn(RepeatEn),
    .Level(Level), .Press(Press), .Release(Release),
    .AnyPress(AnyPress)
  );

  button_sync_multi #(
    .N(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .Bi(bib), .RepeatEn(RepeatEn),
    .Level(lvb), .Press(prb), .Release(rlb), .AnyPress(anyb)
  );

  button_sync_multi #(
    .N(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(2),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_c (
    .Clk(Clk), .Reset(Reset), .Bi(bic), .RepeatEn(RepeatEn),
    .Level(lvc), .Press(prc), .Release(rlc), .AnyPress(anyc)
  );

  // Reference model: level flips after D consecutive disagreeing samples;
  // repeats fire when edges since the anchor reach the current interval.
  bit [N-1:0] mdl[$];
  bit [N-1:0] mlev, mprs, mrls;
  int         mrun[N];
  int         manc[N];
  int         mint[N];
  int         edge_n = 0;

  task automatic model_edge(input logic [N-1:0] b, input logic en,
                            input logic rst);
    bit [N-1:0] bs;
    edge_n++;
    mprs = '0;
    mrls = '0;
    if (rst) begin
      mdl.delete();
      for (int k = 0; k < S; k++) mdl.push_back('0);
      mlev = '0;
      for (int i = 0; i < N; i++) begin
        mrun[i] = 0;
        manc[i] = edge_n;
        mint[i] = RD;
      end
    end else begin
      bs = mdl.pop_front();
      mdl.push_back(b);
      for (int i = 0; i < N; i++) begin
        if (bs[i] != mlev[i]) begin
          mrun[i]++;
          if (mrun[i] == D) begin
            mrun[i] = 0;
            mlev[i] = bs[i];
            if (bs[i]) begin
              mprs[i] = 1'b1;
              manc[i] = edge_n;
              mint[i] = RD;
            end else begin
              mrls[i] = 1'b1;
            end
          end
        end else if (mrun[i] > 0) begin
          mrun[i] = 0;
          manc[i] = edge_n;
          mint[i] = RD;
        end else if (mlev[i]) begin
          if (!en) begin
            manc[i] = edge_n;
            mint[i] = RD;
          end else if (edge_n - manc[i] == mint[i]) begin
            mprs[i] = 1'b1;
            manc[i] = edge_n;
            mint[i] = RR;
          end
        end
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] b;
    logic e, r;
    b = Bi;
    e = RepeatEn;
    r = Reset;
    @(posedge Clk);
    #1;
    model_edge(b, e, r);
    checks++;
    if ({Level, Press, Release, AnyPress} !==
        {mlev, mprs, mrls, |mprs}) begin
      failures++;
      $display("FAIL model edge=%0d got L=%b P=%b R=%b A=%b want L=%b P=%b R=%b A=%b",
               edge_n, Level, Press, Release, AnyPress,
               mlev, mprs, mrls, |mprs);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Bi = '0;
    RepeatEn = 1'b0;
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    checks++;
    if ({Level, Press, Release, AnyPress, prb, lvb, prc, lvc} !== '0) begin
      failures++;
      $display("FAIL reset got L=%b P=%b R=%b A=%b want all 0",
               Level, Press, Release, AnyPress);
    end
  endtask

  task automatic test_basic();
    logic el, ep, er;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      Bi = (k < 20) ? 4'b0001 : 4'b0000;
      step();
      ep = (k == 5);
      el = (k >= 5 && k < 25);
      er = (k == 25);
      checks++;
      if ({Level[0], Press[0], Release[0]} !== {el, ep, er}) begin
        failures++;
        $display("FAIL basic k=%0d got LPR=%b%b%b want %b%b%b",
                 k, Level[0], Press[0], Release[0], el, ep, er);
      end
    end
  endtask

  task automatic test_bounce();
    logic el, ep;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      Bi = (k < 3) ? 4'b0010 : 4'b0000;
      step();
      checks++;
      if ({Level[1], Press[1], Release[1]} !== 3'b000) begin
        failures++;
        $display("FAIL glitch k=%0d got LPR=%b%b%b want 000",
                 k, Level[1], Press[1], Release[1]);
      end
    end
    for (int k = 0; k < 30; k++) begin
      Bi = (k >= 10 && k < 12) ? 4'b0000 : 4'b0010;
      step();
      ep = (k == 5);
      el = (k >= 5);
      checks++;
      if ({Level[1], Press[1], Release[1]} !== {el, ep, 1'b0}) begin
        failures++;
        $display("FAIL dropout k=%0d got LPR=%b%b%b want %b%b0",
                 k, Level[1], Press[1], Release[1], el, ep);
      end
    end
    Bi = '0;
    repeat (8) step();
  endtask

  task automatic test_repeat();
    logic ep, er;
    do_reset();
    RepeatEn = 1'b1;
    for (int k = 0; k < 55; k++) begin
      Bi = (k < 40) ? 4'b0100 : 4'b0000;
      step();
      ep = (k inside {5, 15, 20, 25, 30, 35, 40});
      er = (k == 45);
      checks++;
      if ({Press[2], Release[2]} !== {ep, er}) begin
        failures++;
        $display("FAIL repeat k=%0d got PR=%b%b want %b%b",
                 k, Press[2], Release[2], ep, er);
      end
    end
    RepeatEn = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic el, ep;
    do_reset();
    for (int k = 0; k < 21; k++) begin
      Bi = 4'b0001;
      Reset = (k == 8 || k == 9);
      step();
      ep = (k == 5 || k == 15);
      el = (k >= 5 && k < 8) || (k >= 15);
      checks++;
      if ({Level[0], Press[0]} !== {el, ep}) begin
        failures++;
        $display("FAIL reset_mid k=%0d got LP=%b%b want %b%b",
                 k, Level[0], Press[0], el, ep);
      end
      if (k == 9) begin
        checks++;
        if ({Level, Press, Release, AnyPress} !== '0) begin
          failures++;
          $display("FAIL reset_mid_zero got L=%b P=%b R=%b A=%b want 0",
                   Level, Press, Release, AnyPress);
        end
      end
    end
    Reset = 1'b0;
    Bi = '0;
    repeat (8) step();
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] ep;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      Bi = 4'b1111;
      step();
      ep = (k == 5) ? 4'b1111 : 4'b0000;
      checks++;
      if ({Press, AnyPress} !== {ep, (k == 5)}) begin
        failures++;
        $display("FAIL simultaneous k=%0d got P=%b A=%b want P=%b A=%b",
                 k, Press, AnyPress, ep, (k == 5));
      end
    end
    Bi = '0;
    repeat (8) step();
  endtask

  task automatic test_params();
    do_reset();
    for (int k = 0; k < 14; k++) begin
      bib = 1'b1;
      bic = 1'b1;
      step();
      checks++;
      if ({prb, lvb, prc, lvc} !==
          {(k == 10), (k >= 10), (k == 3), (k >= 3)}) begin
        failures++;
        $display("FAIL params k=%0d got b:PL=%b%b c:PL=%b%b want %b%b %b%b",
                 k, prb, lvb, prc, lvc,
                 (k == 10), (k >= 10), (k == 3), (k >= 3));
      end
    end
    bib = 1'b0;
    bic = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_random();
    int hold[N];
    do_reset();
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          Bi[i] = ~Bi[i];
          hold[i] = ($urandom_range(0, 3) == 0) ?
                    int'($urandom_range(15, 40)) :
                    int'($urandom_range(1, 6));
        end else begin
          hold[i]--;
        end
      end
      if ($urandom_range(0, 49) == 0) RepeatEn = ~RepeatEn;
      Reset = ($urandom_range(0, 299) == 0);
      step();
    end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_repeat();
    test_reset_mid();
    test_simultaneous();
    test_params();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_sync_multi.md
Name: button_sync_multi

Overview:
Parametrised, multi-channel successor to the single-button synchroniser. Each of N asynchronous push-button inputs passes through a configurable flop synchroniser, a counter-based debouncer and a per-channel FSM. The block produces a debounced level, one-cycle press and release pulses, and an optional auto-repeat press pulse while a button is held. It sits between the board pushbuttons and all control FSMs that consume button events.

Parameters:
N, 4, number of independent button channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a press or release (>=2)
REPEAT_DELAY, 10, clock cycles from a press pulse to the first auto-repeat pulse (>=2)
REPEAT_RATE, 5, clock cycles between later auto-repeat pulses (>=2)

Ports:
Clk  input  1  system clock, all logic on posedge
Reset  input  1  synchronous, active-high reset
Bi  input  N  raw asynchronous button inputs, active-high
RepeatEn  input  1  global auto-repeat enable, synchronous
Level  output  N  debounced button level
Press  output  N  one-cycle pulse per accepted press and per auto-repeat
Release  output  N  one-cycle pulse per accepted release
AnyPress  output  1  OR of Press, same cycle

Behaviour:
- Reset (sampled at posedge Clk): all sync flops 0; every channel goes to IDLE; all counters 0; Level, Press, Release and AnyPress 0 in the next cycle. Reset has priority over all other activity, including an operation in progress.
- Synchroniser: Bs[i] is Bi[i] delayed by SYNC_STAGES flops. No logic sits between the sync flops.
- Per-channel FSM states: IDLE, PRESS_WAIT, HELD, REL_WAIT. The debounce counter dcnt is $clog2(DEBOUNCE_CYCLES)+1 bits wide.
- IDLE: if Bs=1, go to PRESS_WAIT and set dcnt=1.
- PRESS_WAIT: if Bs=0, return to IDLE (glitch rejected, no output).
  - Else if dcnt==DEBOUNCE_CYCLES-1, go to HELD and set Press=1 for the next cycle.
  - Else increment dcnt.
- HELD: if Bs=0, go to REL_WAIT and set dcnt=1.
- REL_WAIT: if Bs=1, return to HELD. No new Press is issued, and the repeat counter restarts from 0.
  - Else if dcnt==DEBOUNCE_CYCLES-1, go to IDLE and set Release=1 for the next cycle.
  - Else increment dcnt.
- Level=1 in HELD and REL_WAIT, 0 otherwise. Level is registered and changes in the same cycle as the Press or Release pulse.
- Latency: if Bi rises before edge 0 and stays high, Press is high between edges SYNC_STAGES+DEBOUNCE_CYCLES-1 and SYNC_STAGES+DEBOUNCE_CYCLES. The default is the cycle after edge 5. Release has the same latency from a falling Bi.
- Auto-repeat: the counter rcnt ($clog2 of max(REPEAT_DELAY,REPEAT_RATE))+1 bits) counts cycles in HELD.
  - rcnt clears on entry to HELD, on every Press pulse, and whenever RepeatEn=0.
  - First repeat: Press pulses REPEAT_DELAY cycles after the initial Press.
  - Later repeats: Press pulses every REPEAT_RATE cycles.
  - No repeat pulses occur in REL_WAIT.
  - Deasserting RepeatEn mid-hold suppresses repeats. Reasserting it restarts the count from REPEAT_DELAY.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Unreachable or illegal state encodings go to IDLE on the next edge with outputs 0.
- Press and Release are never high in the same cycle for one channel.

Test Plan:
- Defaults, RepeatEn=0. Bi[0]=1 before edge 0, held until edge 20 -> Press[0] high only in the cycle after edge 5; Level[0] high from edge 5; Release[0] high in the cycle after edge 25; Level[0] low from edge 25.
- Bounce: Bi[1]=1 for 3 cycles, then 0 -> no Press[1], Release[1] or Level[1] activity. Bi[1]=0 for 2 cycles while held -> Level[1] stays 1 and no Release.
- Auto-repeat, RepeatEn=1, Bi[2] held 40 cycles -> Press[2] after edges 5, 15, 20, 25, 30, 35, 40. No pulses after release is accepted. Release[2] after edge 45.
- Reset asserted at edge 8 while Bi[0] is held after a press -> all outputs 0 from edge 9. With Bi still high after Reset drops at edge 10, a new Press occurs 5 edges later (after edge 15).
- Bi[3:0]=4'b1111 applied simultaneously -> Press=4'b1111 for one cycle and AnyPress=1 in that same cycle.
- Re-run with N=1, SYNC_STAGES=3, DEBOUNCE_CYCLES=8 -> Press after edge 10. Repeat with N=1, DEBOUNCE_CYCLES=2 -> Press after edge 3.
